// File: rtl/uart_loader_pkg.sv
// Shared constants for the UART word loader: word geometry and FSM state encodings.
package uart_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_WIDTH     = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/loader_wr_slot.sv
// Single-entry write holding register for the word loader: valid/ready write port,
// auto-incrementing address, accepted-word count and drop detection.
module loader_wr_slot
  import uart_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  i_clk_uart,
  input  logic                  i_rst,
  input  logic                  i_restart,
  input  logic                  i_push,
  input  logic [WORD_WIDTH-1:0] i_push_data,
  input  logic                  i_wr_ready,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [WORD_WIDTH-1:0] o_wr_data,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_dropped
);

  localparam logic [ADDR_WIDTH+1:0] MAX_WORDS = (ADDR_WIDTH+2)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  logic                  accept;
  logic [ADDR_WIDTH+1:0] committed;

  assign accept    = o_wr_en & i_wr_ready;
  // Words already accepted plus the one in flight; once this reaches capacity,
  // any further word would need an address past the end of memory.
  assign committed = {1'b0, o_word_count} + {{(ADDR_WIDTH+1){1'b0}}, o_wr_en};
  assign o_dropped = i_push & ((o_wr_en & ~i_wr_ready) | (committed >= MAX_WORDS));

  always_ff @(posedge i_clk_uart or posedge i_rst) begin
    if (i_rst) begin
      o_wr_en      <= 1'b0;
      o_wr_addr    <= BASE;
      o_wr_data    <= '0;
      o_word_count <= '0;
    end else if (i_restart) begin
      o_wr_en      <= 1'b0;
      o_wr_addr    <= BASE;
      o_word_count <= '0;
    end else begin
      if (accept) begin
        o_word_count <= o_word_count + (ADDR_WIDTH+1)'(1);
        o_wr_addr    <= o_wr_addr + ADDR_WIDTH'(1);
      end
      if (i_push && !o_dropped) begin
        o_wr_en   <= 1'b1;
        o_wr_data <= i_push_data;
      end else if (accept) begin
        o_wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_word_loader.sv
// Packs UART receiver byte strobes little-endian into 32-bit words and writes them
// to instruction memory; the receiver's clear pulse flushes and closes the session.
module uart_word_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  i_clk_uart,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_clear_sign,
  input  logic                  i_wr_ready,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [WORD_WIDTH-1:0] o_wr_data,
  output logic                  o_loading,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_overflow
);

  localparam int               IDX_W    = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [1:0]            state;
  logic [IDX_W-1:0]      byte_idx;
  logic [WORD_WIDTH-1:0] asm_word;
  logic [WORD_WIDTH-1:0] asm_next;
  logic [WORD_WIDTH-1:0] push_data;
  logic                  push;
  logic                  dropped;
  logic                  session_start;
  logic                  overflow;

  assign session_start = (state == ST_IDLE) && i_rx_valid;

  // Byte 0 clears the upper lanes so a flushed partial word comes out zero-padded.
  always_comb begin
    asm_next = (byte_idx == '0) ? '0 : asm_word;
    asm_next[{byte_idx, 3'b000} +: 8] = i_rx_data;
  end

  always_comb begin
    push      = 1'b0;
    push_data = asm_next;
    if (state == ST_LOAD && i_rx_valid && byte_idx == LAST_IDX) begin
      push = 1'b1;
    end else if (state == ST_FLUSH && byte_idx != '0 && !o_wr_en) begin
      push      = 1'b1;
      push_data = asm_word;
    end
  end

  always_ff @(posedge i_clk_uart or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      byte_idx <= '0;
      asm_word <= '0;
      overflow <= 1'b0;
    end else begin
      if (session_start) begin
        overflow <= 1'b0;
      end else if (dropped || (state == ST_FLUSH && i_rx_valid)) begin
        overflow <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            asm_word <= asm_next;
            byte_idx <= IDX_W'(1);
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (i_rx_valid) begin
            asm_word <= asm_next;
            byte_idx <= byte_idx + IDX_W'(1);
          end
          if (i_clear_sign) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // The partial word waits for the slot to drain, then DONE waits for it too.
          if (byte_idx != '0) begin
            if (!o_wr_en) begin
              byte_idx <= '0;
            end
          end else if (!o_wr_en) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  loader_wr_slot #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_wr_slot (
    .i_clk_uart   (i_clk_uart),
    .i_rst        (i_rst),
    .i_restart    (session_start),
    .i_push       (push),
    .i_push_data  (push_data),
    .i_wr_ready   (i_wr_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_word_count (o_word_count),
    .o_dropped    (dropped)
  );

  assign o_loading  = (state == ST_LOAD) || (state == ST_FLUSH);
  assign o_done     = (state == ST_DONE);
  assign o_overflow = overflow;

endmodule

// File: tb/tb_uart_word_loader.sv
// Scoreboard bench for uart_word_loader: a full-size and a 4-word instance share one
// byte stream; expected writes are queued as bytes are driven and popped on each accept.
module tb_uart_word_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        clearSign;
  logic        wrReady;

  logic        wrEn1,    wrEn2;
  logic [9:0]  wrAddr1;
  logic [1:0]  wrAddr2;
  logic [31:0] wrData1,  wrData2;
  logic        loading1, loading2;
  logic        done1,    done2;
  logic [10:0] count1;
  logic [2:0]  count2;
  logic        ovf1,     ovf2;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] expQ1[$];
  logic [63:0] expQ2[$];
  int doneCount1 = 0, doneCount2 = 0;
  int doneMark1  = 0, doneMark2  = 0;
  int sessWr1    = 0, sessWr2    = 0;
  int wrAtDone1  = -1, wrAtDone2 = -1;
  int extra1     = 0, extra2     = 0;

  always #5 clock = ~clock;

  uart_word_loader dut (
    .i_clk_uart   (clock),
    .i_rst        (reset),
    .i_rx_data    (rxData),
    .i_rx_valid   (rxValid),
    .i_clear_sign (clearSign),
    .i_wr_ready   (wrReady),
    .o_wr_en      (wrEn1),
    .o_wr_addr    (wrAddr1),
    .o_wr_data    (wrData1),
    .o_loading    (loading1),
    .o_done       (done1),
    .o_word_count (count1),
    .o_overflow   (ovf1)
  );

  uart_word_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dutSmall (
    .i_clk_uart   (clock),
    .i_rst        (reset),
    .i_rx_data    (rxData),
    .i_rx_valid   (rxValid),
    .i_clear_sign (clearSign),
    .i_wr_ready   (wrReady),
    .o_wr_en      (wrEn2),
    .o_wr_addr    (wrAddr2),
    .o_wr_data    (wrData2),
    .o_loading    (loading2),
    .o_done       (done2),
    .o_word_count (count2),
    .o_overflow   (ovf2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; handshakes are observed on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (wrEn1 && wrReady) begin
        sessWr1++;
        if (expQ1.size() > 0) checkOutput("write_big", {32'(wrAddr1), wrData1}, expQ1.pop_front());
        else extra1++;
      end
      if (wrEn2 && wrReady) begin
        sessWr2++;
        if (expQ2.size() > 0) checkOutput("write_small", {32'(wrAddr2), wrData2}, expQ2.pop_front());
        else extra2++;
      end
      if (done1) begin
        doneCount1++;
        wrAtDone1 = sessWr1;
      end
      if (done2) begin
        doneCount2++;
        wrAtDone2 = sessWr2;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] data, input logic valid, input logic clear);
    rxData    = data;
    rxValid   = valid;
    clearSign = clear;
    @(posedge clock);
    #1;
    rxValid   = 1'b0;
    clearSign = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0);
  endtask

  task automatic sendSeq(input logic [7:0] first, input logic [7:0] step, input int n);
    for (int i = 0; i < n; i++) applyStimulus(first + step * 8'(i), 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] wordOf(input logic [7:0] first, input logic [7:0] step, input int w);
    logic [31:0] word;
    for (int k = 0; k < 4; k++) word[8*k +: 8] = first + step * 8'(4*w + k);
    return word;
  endfunction

  task automatic expectBoth(input int addr, input logic [31:0] data);
    expQ1.push_back({32'(addr), data});
    expQ2.push_back({32'(addr), data});
  endtask

  task automatic startSession();
    doneMark1 = doneCount1;
    doneMark2 = doneCount2;
    sessWr1   = 0;
    sessWr2   = 0;
    wrAtDone1 = -1;
    wrAtDone2 = -1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_big"},   64'({wrEn1, loading1, done1, ovf1, count1, wrAddr1, wrData1}), 64'(0));
    checkOutput({tag, "_small"}, 64'({wrEn2, loading2, done2, ovf2, count2, wrAddr2, wrData2}), 64'(0));
  endtask

  task automatic endSession(input int cnt1, input int cnt2, input logic ov1, input logic ov2);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      seen = (doneCount1 > doneMark1) && (doneCount2 > doneMark2);
      if (seen) break;
      @(posedge clock);
      #1;
    end
    checkOutput("done_seen", 64'(seen), 64'(1));
    idleCycles(3);
    checkOutput("done_pulses_big",   64'(doneCount1 - doneMark1), 64'(1));
    checkOutput("done_pulses_small", 64'(doneCount2 - doneMark2), 64'(1));
    checkOutput("writes_before_done_big",   64'(wrAtDone1), 64'(cnt1));
    checkOutput("writes_before_done_small", 64'(wrAtDone2), 64'(cnt2));
    checkOutput("word_count_big",   64'(count1), 64'(cnt1));
    checkOutput("word_count_small", 64'(count2), 64'(cnt2));
    checkOutput("overflow_big",     64'(ovf1), 64'(ov1));
    checkOutput("overflow_small",   64'(ovf2), 64'(ov2));
    checkOutput("loading_after",    64'({loading1, loading2}), 64'(0));
    checkOutput("pending_expected", 64'(expQ1.size() + expQ2.size()), 64'(0));
    checkOutput("extra_writes",     64'(extra1 + extra2), 64'(0));
  endtask

  initial begin
    reset     = 1'b1;
    rxData    = 8'h00;
    rxValid   = 1'b0;
    clearSign = 1'b0;
    wrReady   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkResetOutputs("reset_state");
    reset = 1'b0;
    idleCycles(2);

    $display("[TB] full words, ready high");
    startSession();
    wrReady = 1'b1;
    expectBoth(0, 32'h44332211);
    expectBoth(1, 32'h88776655);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'h11 * 8'(i + 1), 1'b1, 1'b0);
      if (i == 0) checkOutput("loading_active", 64'({loading1, loading2}), 64'(3));
      if (i % 4 == 3) checkOutput("wr_en_latency", 64'({wrEn1, wrEn2}), 64'(3));
    end
    applyStimulus(8'h00, 1'b0, 1'b1);
    endSession(2, 2, 1'b0, 1'b0);

    $display("[TB] partial word flush");
    startSession();
    expectBoth(0, 32'h44332211);
    expectBoth(1, 32'h00006655);
    sendSeq(8'h11, 8'h11, 6);
    applyStimulus(8'h00, 1'b0, 1'b1);
    endSession(2, 2, 1'b0, 1'b0);

    $display("[TB] busy memory drops second word");
    startSession();
    wrReady = 1'b0;
    expectBoth(0, 32'h44332211);
    sendSeq(8'h11, 8'h11, 8);
    checkOutput("overflow_while_pending", 64'({ovf1, ovf2}), 64'(3));
    checkOutput("wr_en_held",             64'({wrEn1, wrEn2}), 64'(3));
    wrReady = 1'b1;
    idleCycles(1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    endSession(1, 1, 1'b1, 1'b1);

    $display("[TB] capacity limit on the 4-word instance");
    startSession();
    for (int w = 0; w < 5; w++) expQ1.push_back({32'(w), wordOf(8'h01, 8'h01, w)});
    for (int w = 0; w < 4; w++) expQ2.push_back({32'(w), wordOf(8'h01, 8'h01, w)});
    sendSeq(8'h01, 8'h01, 20);
    checkOutput("no_wrap_write_small", 64'(wrEn2), 64'(0));
    checkOutput("capacity_overflow",   64'({ovf1, ovf2}), 64'(1));
    applyStimulus(8'h00, 1'b0, 1'b1);
    endSession(5, 4, 1'b0, 1'b1);

    $display("[TB] reset abandons partial word");
    startSession();
    sendSeq(8'hAA, 8'h11, 2);
    reset = 1'b1;
    #1;
    checkResetOutputs("mid_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    idleCycles(3);
    checkOutput("no_write_after_reset", 64'({wrEn1, wrEn2}), 64'(0));
    startSession();
    expectBoth(0, 32'h04030201);
    sendSeq(8'h01, 8'h01, 4);
    applyStimulus(8'h00, 1'b0, 1'b1);
    endSession(1, 1, 1'b0, 1'b0);

    $display("[TB] clear in idle, clear with last byte");
    startSession();
    applyStimulus(8'h00, 1'b0, 1'b1);
    idleCycles(5);
    checkOutput("idle_clear_loading", 64'({loading1, loading2}), 64'(0));
    checkOutput("idle_clear_done",    64'((doneCount1 - doneMark1) + (doneCount2 - doneMark2)), 64'(0));
    checkOutput("idle_clear_writes",  64'(sessWr1 + sessWr2), 64'(0));
    expectBoth(0, 32'h04030201);
    sendSeq(8'h01, 8'h01, 3);
    applyStimulus(8'h04, 1'b1, 1'b1);
    endSession(1, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
- Sits directly downstream of the UART receiver, in the same clock domain.
- Consumes its one-cycle byte strobes and packs them little-endian into 32-bit words.
- Writes each word to instruction memory through a valid/ready write port, with an auto-incrementing address.
- The receiver's end-of-transmission (clear) pulse closes a load session: any partial word is flushed and completion is reported.

Parameters:
- ADDR_WIDTH, 10: memory word-address width; capacity MAX_WORDS = 2**ADDR_WIDTH.
- BASE_ADDR, 0: first word address of every session.

Ports:
- i_clk_uart  in  1  clock (same clock as the UART receiver).
- i_rst  in  1  asynchronous, active-high reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- i_clear_sign  in  1  end-of-transmission pulse from the receiver.
- i_wr_ready  in  1  memory accepts the write this cycle.
- o_wr_en  out  1  write request; held until accepted.
- o_wr_addr  out  ADDR_WIDTH  word address of the pending write.
- o_wr_data  out  32  word to write.
- o_loading  out  1  session active.
- o_done  out  1  one-cycle pulse when a session completes.
- o_word_count  out  ADDR_WIDTH+1  words accepted by memory in the current/last session.
- o_overflow  out  1  sticky; a word was dropped.

Behaviour:
- Reset (asynchronous, i_rst=1): every output is 0; state IDLE; byte index 0; assembly register 0; next address BASE_ADDR.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE -> LOAD on i_rx_valid:
  - o_word_count and o_overflow clear.
  - Address restarts at BASE_ADDR.
  - That byte is taken as byte 0.
- In IDLE, i_clear_sign is ignored.
- Assembly:
  - byte k (k = 0..3) goes to bits [8k+7:8k]; byte index increments per i_rx_valid and wraps 3 -> 0.
  - On byte 3 the completed word moves into the write slot, which is separate from the assembly register.
- Write timing and handshake:
  - Byte 3 strobed at cycle N: o_wr_en=1 at N+1, with o_wr_addr/o_wr_data stable.
  - o_wr_en holds until a cycle with o_wr_en & i_wr_ready. That cycle the transfer occurs: o_wr_en drops next cycle, the address increments by 1, and o_word_count increments by 1.
  - Assembly of the next word continues while a write is pending.
- Overflow rules (the word is dropped, o_overflow set, and o_overflow stays set until the next session start):
  - A word completes while the slot still holds an unaccepted write.
  - A word completes after MAX_WORDS words have already been accepted this session.
  - The address never wraps.
- LOAD -> FLUSH on i_clear_sign.
  - If i_rx_valid coincides with i_clear_sign, the byte is consumed first, then the flush proceeds.
- FLUSH:
  - Waits for any pending write to be accepted.
  - If the byte index is nonzero, the partial word is zero-padded in its upper bytes and written under the same handshake and capacity rules.
  - The byte index then returns to 0 -> DONE.
  - i_rx_valid during FLUSH is dropped and sets o_overflow.
- DONE:
  - o_done=1 for exactly one cycle; o_loading=0 from this cycle -> IDLE.
  - o_word_count and o_overflow hold until the next session starts.
- o_loading = 1 in LOAD and FLUSH, otherwise 0.
- Reset mid-operation abandons the partial word and any pending write; no write is issued after reset deasserts until new bytes arrive.

Decomposition:
- Package uart_loader_pkg holds:
  - the state enumeration (IDLE/LOAD/FLUSH/DONE);
  - BYTES_PER_WORD = 4;
  - WORD_WIDTH = 32.
- One natural sub-module, loader_wr_slot: the single-entry write holding register with valid/ready and overflow detect.
- All other logic lives in uart_word_loader.

Test Plan:
- Bytes 11,22,33,44,55,66,77,88 with i_wr_ready=1, then i_clear_sign -> writes addr0=0x44332211 and addr1=0x88776655, each with o_wr_en one cycle after byte 3; o_word_count=2; one o_done pulse; o_overflow=0.
- Bytes 11..66, then clear -> addr0=0x44332211, addr1=0x00006655; o_done only after the second write is accepted; count=2.
- i_wr_ready=0 while 8 bytes arrive -> second word dropped and o_overflow=1; raise ready -> only addr0=0x44332211 written; count=1.
- ADDR_WIDTH=2, 20 bytes -> 4 writes at addr0..3; fifth word dropped; o_overflow=1; count=4; address never wraps to 0.
- Bytes AA,BB, then reset pulse -> all outputs 0; then 01,02,03,04 -> addr0=0x04030201 with no trace of AA/BB.
- i_clear_sign in IDLE -> no o_done, no write, o_loading stays 0; clear coincident with byte 4 of a word -> that word is written, then o_done.
